// File: rtl/joystick_pkg.sv
// joystick_pkg: shared joystick bit positions, vector type and direction resolution
package joystick_pkg;
    localparam int JOY_W = 5;
    localparam int JOY_FIRE = 0;
    localparam int JOY_LEFT = 1;
    localparam int JOY_RIGHT = 2;
    localparam int JOY_DOWN = 3;
    localparam int JOY_UP = 4;
    typedef logic [0:JOY_W-1] joy_t;
    // Opposing directions cancel each other; fire passes through untouched.
    function automatic joy_t resolve(input joy_t v);
        joy_t r;
        r = v;
        r[JOY_UP] = v[JOY_UP] & ~v[JOY_DOWN];
        r[JOY_DOWN] = v[JOY_DOWN] & ~v[JOY_UP];
        r[JOY_LEFT] = v[JOY_LEFT] & ~v[JOY_RIGHT];
        r[JOY_RIGHT] = v[JOY_RIGHT] & ~v[JOY_LEFT];
        return r;
    endfunction
endpackage

// File: rtl/joystick_conditioner_debounce_bit.sv
// debounce_bit: 2-FF synchroniser plus tick-counted debounce of one active-low pin
module debounce_bit #(
    parameter int DEBOUNCE_US = 2000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic raw_n,
    output logic d
);
    localparam int CW = $clog2(DEBOUNCE_US + 1);
    logic [1:0] sync;
    logic [CW-1:0] c;
    logic s;
    assign s = ~sync[1];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b11;
            c <= '0;
            d <= 1'b0;
        end else begin
            sync <= {sync[0], raw_n};
            if (s == d) begin
                c <= '0;
            end else if (tick) begin
                if (c == CW'(DEBOUNCE_US - 1)) begin
                    d <= s;
                    c <= '0;
                end else begin
                    c <= c + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/joystick_conditioner.sv
// joystick_conditioner: debounce, direction resolution, autofire and port swap
// for the two DB9 joystick ports feeding the mainboard.
module joystick_conditioner
    import joystick_pkg::*;
#(
    parameter int CLK_HZ = 108000000,
    parameter int DEBOUNCE_US = 2000,
    parameter int AUTOFIRE_HZ = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [0:JOY_W-1] fa_n,
    input  logic [0:JOY_W-1] fb_n,
    input  logic [1:0]       autofire_en,
    input  logic             swap,
    output joy_t             joy1,
    output joy_t             joy2
);
    localparam int TICK_DIV = (CLK_HZ / 1000000 < 1) ? 1 : CLK_HZ / 1000000;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HP = (CLK_HZ / (2 * AUTOFIRE_HZ) < 1) ? 1 : CLK_HZ / (2 * AUTOFIRE_HZ);
    localparam int HW = (HP > 1) ? $clog2(HP) : 1;

    logic [TW-1:0] tick_cnt;
    logic tick;
    logic [0:JOY_W-1] raw_n [2];
    joy_t db [2];
    joy_t res [2];

    assign tick = tick_cnt == TW'(TICK_DIV - 1);
    assign raw_n[0] = fa_n;
    assign raw_n[1] = fb_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tick_cnt <= '0;
        else tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    for (genvar i = 0; i < 2; i++) begin : g_port
        for (genvar j = 0; j < JOY_W; j++) begin : g_bit
            debounce_bit #(.DEBOUNCE_US(DEBOUNCE_US)) u_db (
                .clk(clk),
                .reset_n(reset_n),
                .tick(tick),
                .raw_n(raw_n[i][j]),
                .d(db[i][j])
            );
        end
        logic [HW-1:0] af_cnt;
        logic fire, fire_q, ph_q, ph, wrap;
        joy_t rv;
        assign fire = db[i][JOY_FIRE];
        // The press cycle itself counts as the first high cycle, so a shot is immediate.
        assign ph = (fire & ~fire_q) | ph_q;
        assign wrap = af_cnt == HW'(HP - 1);
        assign rv = resolve(db[i]);
        assign res[i] = {fire & (autofire_en[i] ? ph : 1'b1), rv[JOY_LEFT:JOY_UP]};
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                af_cnt <= '0;
                fire_q <= 1'b0;
                ph_q <= 1'b0;
            end else begin
                fire_q <= fire;
                af_cnt <= (!fire || wrap) ? '0 : af_cnt + 1'b1;
                ph_q <= fire & (wrap ? ~ph : ph);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            joy1 <= '0;
            joy2 <= '0;
        end else begin
            joy1 <= swap ? res[1] : res[0];
            joy2 <= swap ? res[0] : res[1];
        end
    end
endmodule

// File: tb/tb_joystick_conditioner.sv
// tb_joystick_conditioner: directed plan checks plus randomized stimulus against a
// behavioural model of the conditioner.
module tb_joystick_conditioner;
    localparam int CLK_HZ = 4000000;
    localparam int DEB = 4;
    localparam int AF_HZ = 100000;
    localparam int TD = CLK_HZ / 1000000;
    localparam int HP = CLK_HZ / (2 * AF_HZ);

    logic clk, reset_n, swap;
    logic [0:4] fa_n, fb_n;
    logic [1:0] autofire_en;
    logic [0:4] joy1, joy2;
    int n_checks = 0, n_fail = 0;

    joystick_conditioner #(.CLK_HZ(CLK_HZ), .DEBOUNCE_US(DEB), .AUTOFIRE_HZ(AF_HZ)) dut (
        .clk(clk), .reset_n(reset_n), .fa_n(fa_n), .fb_n(fb_n),
        .autofire_en(autofire_en), .swap(swap), .joy1(joy1), .joy2(joy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: inputs seen two edges late, a pin is accepted after differing from its
    // held value across DEB consecutive ticks, autofire high for the first HP cycles
    // of every 2*HP since the press.
    int k, held [2], run [2][5];
    logic [0:4] rh0 [2], rh1 [2], md [2], mr [2], v, sv, m1, m2;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k = 0;
            m1 = '0;
            m2 = '0;
            for (int p = 0; p < 2; p++) begin
                rh0[p] = '1;
                rh1[p] = '1;
                md[p] = '0;
                held[p] = 0;
                for (int b = 0; b < 5; b++) run[p][b] = 0;
            end
        end else begin
            k++;
            for (int p = 0; p < 2; p++) begin
                v = md[p];
                if (v[3] && v[4]) begin v[3] = 1'b0; v[4] = 1'b0; end
                if (v[1] && v[2]) begin v[1] = 1'b0; v[2] = 1'b0; end
                if (autofire_en[p] && (held[p] / HP) % 2 == 1) v[0] = 1'b0;
                mr[p] = v;
                held[p] = md[p][0] ? held[p] + 1 : 0;
                sv = ~rh1[p];
                for (int b = 0; b < 5; b++) begin
                    if (sv[b] == md[p][b]) run[p][b] = 0;
                    else if ((k - 1) % TD == TD - 1) begin
                        if (run[p][b] == DEB - 1) begin
                            md[p][b] = sv[b];
                            run[p][b] = 0;
                        end else run[p][b]++;
                    end
                end
                rh1[p] = rh0[p];
            end
            rh0[0] = fa_n;
            rh0[1] = fb_n;
            m1 = swap ? mr[1] : mr[0];
            m2 = swap ? mr[0] : mr[1];
        end
    end

    always @(negedge clk) check("model", {joy1, joy2}, {m1, m2});

    task automatic wait_bit(input int port, input int idx, input logic lvl, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((port == 0) ? joy1[idx] : joy2[idx]) !== lvl && n < 40);
    endtask

    int n, nz;
    initial begin
        reset_n = 1'b0;
        fa_n = '0;
        fb_n = '0;
        autofire_en = 2'b00;
        swap = 1'b0;
        #25;
        check("rst_joy1", joy1, 5'b00000);
        check("rst_joy2", joy2, 5'b00000);
        @(negedge clk);
        reset_n = 1'b1;
        wait_bit(0, 0, 1'b1, n);
        check("rst_lat", n >= 16 && n <= 19, 1);
        check("rst_val1", joy1, 5'b10000);
        check("rst_val2", joy2, 5'b10000);

        fa_n = '1;
        fb_n = '1;
        repeat (25) @(negedge clk);
        check("released", {joy1, joy2}, 10'd0);
        fa_n[4] = 1'b0;
        repeat (10) @(negedge clk);
        fa_n[4] = 1'b1;
        nz = 0;
        repeat (30) begin
            @(negedge clk);
            if (joy1 != 0) nz++;
        end
        check("glitch", nz, 0);
        fa_n[4] = 1'b0;
        wait_bit(0, 4, 1'b1, n);
        check("up_rise_lat", n >= 16 && n <= 19, 1);
        repeat (30 - n) @(negedge clk);
        fa_n[4] = 1'b1;
        wait_bit(0, 4, 1'b0, n);
        check("up_fall_lat", n >= 16 && n <= 19, 1);

        fa_n[4] = 1'b0;
        repeat (25) @(negedge clk);
        fa_n[3] = 1'b0;
        repeat (25) @(negedge clk);
        check("opposed", joy1[3:4], 2'b00);
        fa_n[4] = 1'b1;
        repeat (25) @(negedge clk);
        check("down_only", joy1[3:4], 2'b10);
        fa_n = '1;
        repeat (25) @(negedge clk);

        autofire_en = 2'b01;
        fa_n[0] = 1'b0;
        fb_n[0] = 1'b0;
        wait_bit(0, 0, 1'b1, n);
        for (int i = 0; i < 160; i++) begin
            if (i % 10 == 0) begin
                check("af_a", joy1[0], (i / HP) % 2 == 0);
                check("af_b", joy2[0], 1);
            end
            @(negedge clk);
        end
        #3 reset_n = 1'b0;
        #1;
        check("async_joy1", joy1, 5'b00000);
        check("async_joy2", joy2, 5'b00000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_bit(0, 0, 1'b1, n);
        check("rerun_lat", n >= 16 && n <= 19, 1);

        autofire_en = 2'b00;
        fa_n = '1;
        fb_n = '1;
        repeat (25) @(negedge clk);
        fa_n[1] = 1'b0;
        repeat (25) @(negedge clk);
        check("pre_swap", {joy1[1], joy2[1]}, 2'b10);
        swap = 1'b1;
        @(negedge clk);
        check("swap", {joy1[1], joy2[1]}, 2'b01);
        swap = 1'b0;

        repeat (120) begin
            fa_n = 5'($urandom);
            fb_n = 5'($urandom);
            if ($urandom_range(3) == 0) autofire_en = 2'($urandom);
            if ($urandom_range(3) == 0) swap = 1'($urandom_range(1));
            repeat ($urandom_range(40, 1)) @(negedge clk);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
